// File: rtl/key_debounce_4ch.sv
// key_debounce_4ch: per-channel 2-flop sync plus debounce FSM giving level, press and release strobes.
// Define KEY_REPEAT_EN to re-pulse Key_Press while a key stays held.
module key_debounce_4ch #(
  parameter int N_KEYS               = 4,
  parameter int DEBOUNCE_CYCLES      = 1000000,
  parameter int REPEAT_DELAY_CYCLES  = 25000000,
  parameter int REPEAT_PERIOD_CYCLES = 5000000
) (
  input  logic              CLK,
  input  logic              Rstn,
  input  logic [N_KEYS-1:0] Key_In,
  output logic [N_KEYS-1:0] Key_Level,
  output logic [N_KEYS-1:0] Key_Press,
  output logic [N_KEYS-1:0] Key_Release
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
`ifdef KEY_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES + 1);
`endif
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 2**24 ||
      REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_bad_param
    $error("key_debounce_4ch: cycle parameter out of range");
  end
  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          s1_q, s2_q, level_q, press_q, release_q, last;
    assign last = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    logic [HW-1:0] hold_q, hold_nxt;
    logic          hold_wrap;
    assign hold_nxt  = hold_q + 1'b1;
    assign hold_wrap = hold_nxt == HW'(REPEAT_DELAY_CYCLES + REPEAT_PERIOD_CYCLES);
`endif
    always_ff @(posedge CLK or negedge Rstn) begin
      if (!Rstn) begin
        s1_q      <= 1'b1;
        s2_q      <= 1'b1;
        state_q   <= IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
        hold_q    <= '0;
`endif
      end else begin
        s1_q      <= Key_In[g];
        s2_q      <= s1_q;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state_q)
          IDLE: if (!s2_q) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
          PRESS_WAIT: if (s2_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (last) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
          PRESSED: begin
            if (s2_q) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= '0;
            end
`ifdef KEY_REPEAT_EN
            // hold counter parks at the delay value so later strobes are periodic
            else begin
              hold_q  <= hold_wrap ? HW'(REPEAT_DELAY_CYCLES) : hold_nxt;
              press_q <= hold_wrap || hold_nxt == HW'(REPEAT_DELAY_CYCLES);
            end
`endif
          end
          RELEASE_WAIT: if (!s2_q) begin
            state_q <= PRESSED;
            cnt_q   <= '0;
          end else if (last) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            cnt_q     <= '0;
`ifdef KEY_REPEAT_EN
            hold_q    <= '0;
`endif
          end else cnt_q <= cnt_q + 1'b1;
          default: state_q <= IDLE;
        endcase
      end
    end
    assign Key_Level[g]   = level_q;
    assign Key_Press[g]   = press_q;
    assign Key_Release[g] = release_q;
  end
endmodule

// File: tb/tb_key_debounce_4ch.sv
// tb_key_debounce_4ch: directed test-plan cases plus random bounce against a run-length reference model.
module tb_key_debounce_4ch;
  localparam int D  = 16;
  localparam int RD = 40;
  localparam int RP = 10;

  logic       CLK = 1'b0;
  logic       Rstn = 1'b0;
  logic [3:0] Key_In = 4'hF;
  logic [3:0] Key_Level, Key_Press, Key_Release;
  int         checks = 0, passes = 0;

  key_debounce_4ch #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY_CYCLES(RD), .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .CLK(CLK), .Rstn(Rstn), .Key_In(Key_In),
    .Key_Level(Key_Level), .Key_Press(Key_Press), .Key_Release(Key_Release)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  // Reference: a pin value two edges old is what the debouncer sees; the level flips
  // once D+1 consecutive samples disagree with it, and any agreeing sample restarts the run.
  logic       s1 [4], s2 [4];
  int         run [4], hold [4];
  logic [3:0] e_lvl, e_pr, e_rl;
  logic       samp;
  initial for (int k = 0; k < 4; k++) begin s1[k] = 1; s2[k] = 1; run[k] = 0; hold[k] = 0; end
  initial begin e_lvl = 0; e_pr = 0; e_rl = 0; end

  always @(posedge CLK) begin
    #1;
    for (int k = 0; k < 4; k++) begin
      if (!Rstn) begin
        s1[k] = 1; s2[k] = 1; run[k] = 0; hold[k] = 0;
        e_lvl[k] = 0; e_pr[k] = 0; e_rl[k] = 0;
      end else begin
        samp = s2[k]; s2[k] = s1[k]; s1[k] = Key_In[k];
        e_pr[k] = 0; e_rl[k] = 0;
        if (!samp != e_lvl[k]) begin
          run[k]++;
          if (run[k] == D + 1) begin
            run[k] = 0;
            e_lvl[k] = ~e_lvl[k];
            if (e_lvl[k]) e_pr[k] = 1;
            else begin e_rl[k] = 1; hold[k] = 0; end
          end
        end else begin
`ifdef KEY_REPEAT_EN
          if (e_lvl[k] && run[k] == 0) begin
            hold[k]++;
            if (hold[k] == RD || (hold[k] > RD && (hold[k] - RD) % RP == 0)) e_pr[k] = 1;
          end
`endif
          run[k] = 0;
        end
      end
    end
    chk("model_level", Key_Level, e_lvl);
    chk("model_press", Key_Press, e_pr);
    chk("model_release", Key_Release, e_rl);
  end

  task automatic drive(input logic [3:0] v);
    @(negedge CLK);
    Key_In = v;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  initial begin
    logic [3:0] acc;
    int left [4];
    repeat (3) @(negedge CLK);
    chk("reset_outputs", Key_Level | Key_Press | Key_Release, 4'b0000);
    Rstn = 1'b1;
    edges(5);

    // 1: single press and its release latency
    drive(4'b1110);
    edges(18); chk("t1_press_e18", Key_Press, 4'b0000);
    edges(1);  chk("t1_press_e19", Key_Press, 4'b0001); chk("t1_level_e19", Key_Level, 4'b0001);
    edges(1);  chk("t1_press_e20", Key_Press, 4'b0000); chk("t1_level_e20", Key_Level, 4'b0001);
    drive(4'b1111);
    edges(18); chk("t1_rel_e18", Key_Release, 4'b0000);
    edges(1);  chk("t1_rel_e19", Key_Release, 4'b0001); chk("t1_lvl_off", Key_Level, 4'b0000);
    edges(20);

    // 2: short 10-cycle press is rejected
    drive(4'b1101);
    repeat (10) @(negedge CLK);
    Key_In = 4'hF;
    acc = 0;
    for (int i = 0; i < 40; i++) begin edges(1); acc |= Key_Level | Key_Press | Key_Release; end
    chk("t2_glitch_quiet", acc, 4'b0000);

    // 3: held key bounces high 5 cycles, then clean release
    drive(4'b1011);
    edges(25); chk("t3_held", Key_Level, 4'b0100);
    drive(4'b1111);
    acc = 0;
    for (int i = 0; i < 5; i++) begin edges(1); acc |= Key_Release; end
    drive(4'b1011);
    for (int i = 0; i < 30; i++) begin edges(1); acc |= Key_Release; end
    chk("t3_bounce_no_rel", acc, 4'b0000);
    drive(4'b1111);
    edges(18); chk("t3_rel_e18", Key_Release, 4'b0000);
    edges(1);  chk("t3_rel_e19", Key_Release, 4'b0100);
    edges(20);

    // 4: two keys on the same edge
    drive(4'b0110);
    edges(18); chk("t4_press_e18", Key_Press, 4'b0000);
    edges(1);  chk("t4_press_e19", Key_Press, 4'b1001);
    drive(4'b1111);
    edges(40);

    // 5: reset while channel 1 counts, key still held afterwards
    drive(4'b1101);
    edges(11);
    @(negedge CLK); Rstn = 1'b0;
    #1 chk("t5_in_reset", Key_Level | Key_Press | Key_Release, 4'b0000);
    edges(3); chk("t5_reset_hold", Key_Level | Key_Press | Key_Release, 4'b0000);
    @(negedge CLK); Rstn = 1'b1;
    edges(18); chk("t5_press_e18", Key_Press, 4'b0000);
    edges(1);  chk("t5_press_e19", Key_Press, 4'b0010);
    drive(4'b1111);
    edges(40);

`ifdef KEY_REPEAT_EN
    // 6: auto-repeat at +40 then every +10
    drive(4'b1110);
    edges(19); chk("t6_accept", Key_Press, 4'b0001);
    for (int e = 1; e <= 100; e++) begin
      edges(1);
      chk("t6_repeat", Key_Press, {3'b000, e == 40 || (e > 40 && (e - 40) % 10 == 0)});
      chk("t6_level", Key_Level, 4'b0001);
    end
    drive(4'b1111);
    edges(40);
`endif

    // random bounce, holds and occasional resets
    for (int k = 0; k < 4; k++) left[k] = $urandom_range(1, 30);
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK);
      if ($urandom_range(0, 799) == 0) begin
        Rstn = 1'b0;
        repeat (2) @(negedge CLK);
        Rstn = 1'b1;
      end
      for (int k = 0; k < 4; k++) begin
        if (left[k] == 0) begin
          Key_In[k] = ~Key_In[k];
          left[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(18, 70) : $urandom_range(1, 20);
        end else left[k]--;
      end
    end
    drive(4'b1111);
    edges(40);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
